// File: rtl/act_func_lut_requester.sv
// act_func_lut_requester: maps signed MAC accumulators to activation-ROM
// addresses, captures the ROM output and presents it downstream with a
// neuron index and an end-of-layer pulse.
module act_func_lut_requester #(
  parameter int ACC_WIDTH   = 26,
  parameter int FRAC_SHIFT  = 0,
  parameter int NUM_NEURONS = 32,
  parameter int IDX_WIDTH   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [ACC_WIDTH-1:0] in_acc,
  output logic                 in_ready,
  output logic [10:0]          lut_addr,
  input  logic [7:0]           lut_q,
  output logic                 out_valid,
  output logic [7:0]           out_data,
  input  logic                 out_ready,
  output logic [IDX_WIDTH-1:0] neuron_idx,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic signed [ACC_WIDTH-1:0] SAT_HI   = ACC_WIDTH'(1023);
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO   = ACC_WIDTH'(-1024);
  localparam logic [IDX_WIDTH-1:0]        LAST_IDX = IDX_WIDTH'(NUM_NEURONS - 1);

  state_t state, state_next;

  logic signed [ACC_WIDTH-1:0] acc_shifted;
  logic signed [10:0]          acc_sat;
  logic [10:0]                 addr_mapped;
  logic                        accept;
  logic                        take;

  assign accept = in_valid && in_ready;
  assign take   = (state == HOLD) && out_ready;

  // Ready only while idle; forced low during reset so nothing is accepted.
  assign in_ready = (state == IDLE) && !rst;

  // Scale, saturate to the signed 11-bit range and convert to offset binary.
  always_comb begin
    acc_shifted = $signed(in_acc) >>> FRAC_SHIFT;
    if (acc_shifted > SAT_HI) begin
      acc_sat = 11'sd1023;
    end else if (acc_shifted < SAT_LO) begin
      acc_sat = -11'sd1024;
    end else begin
      acc_sat = acc_shifted[10:0];
    end
    addr_mapped = {~acc_sat[10], acc_sat[9:0]};
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one ROM read per acceptance, then wait for downstream.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: address, captured result, index and layer pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_addr   <= 11'h000;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      neuron_idx <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if ((state == IDLE) && accept) begin
        lut_addr <= addr_mapped;
      end
      if (state == CAPTURE) begin
        out_data  <= lut_q;
        out_valid <= 1'b1;
      end
      if (take) begin
        out_valid <= 1'b0;
        if (neuron_idx == LAST_IDX) begin
          neuron_idx <= '0;
          done       <= 1'b1;
        end else begin
          neuron_idx <= neuron_idx + IDX_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_act_func_lut_requester.sv
// Testbench for act_func_lut_requester: directed vectors, scoreboard queue
// filled at acceptance and drained by a monitor on downstream handshakes.
module tb_act_func_lut_requester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [25:0] in_acc = '0;
  logic        in_ready;
  logic [10:0] lut_addr;
  logic [7:0]  lut_q = '0;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b1;
  logic [4:0]  neuron_idx;
  logic        done;

  // Second instance exercising the fractional shift.
  logic        in_valid2 = 1'b0;
  logic [25:0] in_acc2 = '0;
  logic        in_ready2;
  logic [10:0] lut_addr2;
  logic [7:0]  lut_q2 = '0;
  logic        out_valid2;
  logic [7:0]  out_data2;
  logic [4:0]  neuron_idx2;
  logic        done2;

  act_func_lut_requester #(.ACC_WIDTH(26), .FRAC_SHIFT(0), .NUM_NEURONS(32), .IDX_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_acc(in_acc), .in_ready(in_ready),
    .lut_addr(lut_addr), .lut_q(lut_q), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .neuron_idx(neuron_idx), .done(done)
  );

  act_func_lut_requester #(.ACC_WIDTH(26), .FRAC_SHIFT(4), .NUM_NEURONS(32), .IDX_WIDTH(5)) dut_shift (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_acc(in_acc2), .in_ready(in_ready2),
    .lut_addr(lut_addr2), .lut_q(lut_q2), .out_valid(out_valid2), .out_data(out_data2),
    .out_ready(1'b1), .neuron_idx(neuron_idx2), .done(done2)
  );

  always #5 clk = ~clk;

  // Registered ROM model: rom[a] = a[10:3].
  always @(posedge clk) begin
    lut_q  <= lut_addr[10:3];
    lut_q2 <= lut_addr2[10:3];
  end

  typedef struct packed {
    logic [7:0] data;
    logic [4:0] idx;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [4:0]  exp_idx = '0;
  logic        exp_done_pending = 1'b0;
  int          done_count = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Monitor: pops and compares on every downstream handshake; checks done.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_count++;
      if (done || exp_done_pending) check("done_pulse", 32'(done), 32'(exp_done_pending));
      exp_done_pending = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 32'(out_valid), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          check("neuron_idx", 32'(neuron_idx), 32'(e.idx));
          exp_done_pending = (e.idx == 5'd31);
        end
      end
    end
  end

  // Issue one accumulator once the DUT is idle; push the expected result.
  task automatic send(input logic [25:0] acc, input logic [10:0] exp_addr);
    int budget;
    exp_t e;
    budget = 0;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_acc   = acc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lut_addr", 32'(lut_addr), 32'(exp_addr));
    e.data = exp_addr[10:3];
    e.idx  = exp_idx;
    exp_q.push_back(e);
    exp_idx = exp_idx + 5'd1;
  endtask

  // Called right after send: out_valid must rise exactly two edges later.
  task automatic latency_check();
    check("lat_e0_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_e2_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  held_data;
    logic [10:0] held_addr;
    int          budget;
    int          done_base;

    // Reset state.
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_lut_addr", 32'(lut_addr), 32'h000);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_neuron_idx", 32'(neuron_idx), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Mapping, FRAC_SHIFT = 0.
    send(26'd0, 11'h400);
    latency_check();
    send(-26'sd1, 11'h3FF);
    send(26'd5000, 11'h7FF);
    send(-26'sd5000, 11'h000);
    drain();

    // Mapping, FRAC_SHIFT = 4.
    @(negedge clk);
    in_valid2 = 1'b1; in_acc2 = 26'h0000A0;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    check("shift_addr_160", 32'(lut_addr2), 32'h40A);
    repeat (5) @(negedge clk);
    in_valid2 = 1'b1; in_acc2 = -26'sd17;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    check("shift_addr_m17", 32'(lut_addr2), 32'h3FE);

    // Backpressure: ten stalled cycles with stable outputs.
    out_ready = 1'b0;
    send(26'd300, 11'h52C);
    budget = 0;
    while (!out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("bp_valid_rise", 32'(out_valid), 32'd1);
    held_data = 8'hA5; // 0x52C[10:3]
    held_addr = 11'h52C;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'(held_data));
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_lut_addr", 32'(lut_addr), 32'(held_addr));
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_after_in_ready", 32'(in_ready), 32'd1);
    check("bp_after_valid", 32'(out_valid), 32'd0);
    check("bp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Ignored input during ISSUE..HOLD.
    out_ready = 1'b0;
    send(-26'sd100, 11'h39C);
    in_valid = 1'b1;
    in_acc   = 26'd777;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_acc = 26'(i * 1234 - 2000);
      check("ign_lut_addr", 32'(lut_addr), 32'h39C);
    end
    check("ign_holding", 32'(out_valid), 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (6) begin
      @(negedge clk);
      check("ign_no_extra", 32'(out_valid), 32'd0);
    end

    // Reset mid-operation, asserted while in CAPTURE.
    send(26'd100, 11'h464);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    exp_idx = '0;
    exp_done_pending = 1'b0;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_addr", 32'(lut_addr), 32'h000);
    check("mid_rst_idx", 32'(neuron_idx), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_hold_ready", 32'(in_ready), 32'd0);
      check("mid_rst_hold_valid", 32'(out_valid), 32'd0);
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Layer count: post-reset result is index 0, then 31 more.
    done_base = done_count;
    send(-26'sd1, 11'h3FF);
    latency_check();
    for (int i = 1; i < 32; i++) begin
      send(26'(i * 64 - 1024), 11'(i * 64));
    end
    drain();
    @(negedge clk);
    check("layer_done_count", 32'(done_count - done_base), 32'd1);
    check("layer_idx_wrap", 32'(neuron_idx), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/act_func_lut_requester.md
# act_func_lut_requester

Initiator side of the activation-function lookup. Accepts signed MAC accumulator values over a valid/ready stream, scales and saturates each into an 11-bit offset-binary LUT address, and drives the registered 2048x8 activation ROM (1-cycle read latency). It then captures the 8-bit activation and presents it downstream with a neuron index and an end-of-layer pulse. It sits between the MAC array and the layer output buffer.

## Interface
- ACC_WIDTH, 26: width of signed accumulator input (must be ≥ 11 + FRAC_SHIFT).
- FRAC_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.
- NUM_NEURONS, 32: results per layer; sets index wrap and `done` timing.
- IDX_WIDTH, 5: width of `neuron_idx` (≥ clog2(NUM_NEURONS)).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  accumulator valid.
- in_acc  in  ACC_WIDTH  signed accumulator.
- in_ready  out  1  block can accept an accumulator.
- lut_addr  out  11  registered address to the activation ROM.
- lut_q  in  8  ROM data, valid one clock after `lut_addr` is sampled.
- out_valid  out  1  activation result valid.
- out_data  out  8  activation result.
- out_ready  in  1  downstream accepts result.
- neuron_idx  out  IDX_WIDTH  index of the result on `out_data`.
- done  out  1  one-cycle pulse when the last result of a layer is taken.

## Operation
- Address map: s = in_acc >>> FRAC_SHIFT (arithmetic). s > 1023 saturates to 1023; s < −1024 saturates to −1024. lut_addr = s + 1024, i.e. {~s[10], s[9:0]}.
- FSM states: IDLE, ISSUE, CAPTURE, HOLD.
  - IDLE: in_ready = 1. On in_valid && in_ready, register the mapped address into lut_addr and go to ISSUE.
  - ISSUE: wait for the ROM to sample lut_addr. Unconditionally go to CAPTURE.
  - CAPTURE: out_data <= lut_q, out_valid <= 1, go to HOLD.
  - HOLD: out_valid = 1, and out_data and neuron_idx are stable. On out_ready, clear out_valid, increment neuron_idx and go to IDLE.
- in_ready is combinational: it is 1 only in IDLE and is 0 while rst is high.
- neuron_idx wraps to 0 after NUM_NEURONS−1. done pulses for one cycle in the cycle after the handshake on index NUM_NEURONS−1, coincident with the index wrapping to 0.
- lut_addr holds its last value outside IDLE acceptance. In ISSUE, CAPTURE and HOLD, in_valid and in_acc are ignored.
- Downstream stalls (out_ready low) hold HOLD indefinitely, with no data loss and no extra ROM reads.

## Timing
- Reset values (asynchronous, immediate): state IDLE, lut_addr 0x000, out_valid 0, out_data 0x00, neuron_idx 0, done 0.
- Acceptance at edge E0, then:
  - lut_addr updates at E0.
  - The ROM registers q at E1.
  - out_valid and out_data update at E2.
- Latency from acceptance edge to out_valid high is 2 cycles.
- Best-case throughput is 1 result per 4 cycles when out_ready is tied high: accept, ISSUE, CAPTURE, HOLD handshake, next accept.
- If out_ready is already high when HOLD is entered, the handshake completes in that first HOLD cycle.
- If rst asserts mid-transaction, the in-flight result is discarded, all outputs return to reset values immediately, and neuron_idx restarts at 0. Nothing is emitted after reset releases until a new acceptance.

## Test plan
- Mapping with FRAC_SHIFT=0 and ROM model rom[a] = a[10:3]:
  - in_acc 0 → lut_addr 0x400, out_data 0x80.
  - in_acc −1 → 0x3FF, out_data 0x7F.
  - in_acc 5000 → 0x7FF, out_data 0xFF.
  - in_acc −5000 → 0x000, out_data 0x00.
- Shift with FRAC_SHIFT=4: in_acc 0x0000A0 (160) → s = 10 → lut_addr 0x40A. in_acc −17 → s = −2 → lut_addr 0x3FE.
- Backpressure: hold out_ready low for 10 cycles after out_valid. out_valid and out_data stay stable, in_ready stays 0, lut_addr is unchanged. After out_ready rises, one handshake occurs and then in_ready = 1.
- Layer count: stream 32 accumulators with out_ready high. neuron_idx reads 0..31 on successive results, done pulses exactly once after result 31, and the index then reads 0.
- Reset mid-op: assert rst in CAPTURE. out_valid stays 0, in_ready = 0 during reset, and the next accepted value returns with neuron_idx 0 after 2 cycles.
- Ignored input: toggle in_valid and in_acc during ISSUE and HOLD. Exactly one result is produced per IDLE acceptance.
